// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and the
// device-to-host receive path.
package ps2_pkg;

  // Host transmitter state machine encoding.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    WAIT_DEV  = 3'd3,
    SHIFT     = 3'd4,
    ACK_WAIT  = 3'd5,
    LINE_IDLE = 3'd6,
    FINISH    = 3'd7
  } ps2_tx_state_t;

  // Transaction result codes reported on err_code.
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_START_TO = 2'b01;
  localparam logic [1:0] ERR_PKT_TO   = 2'b10;
  localparam logic [1:0] ERR_NACK     = 2'b11;

  // Common device commands.
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Index of the last bit presented by the host (stop bit) plus one.
  localparam logic [3:0] FRAME_END_IDX = 4'd10;

  // Converts a duration in microseconds to a number of clk cycles.
  // The product is formed in 64 bits so large clock rates cannot overflow
  // before the result is narrowed.
  function automatic int unsigned us2cycles(input int unsigned clk_hz,
                                            input int unsigned us);
    longint unsigned l_cycles;
    l_cycles = 64'(clk_hz / 32'd1_000_000) * 64'(us);
    return l_cycles[31:0];
  endfunction

  // Largest of three cycle constants; sizes the shared timeout counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins plus a
// falling-edge detector on the synchronized clock. Shared with the receiver.
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst,       // synchronous, active-low
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_s,
  output logic o_data_s,
  output logic o_clk_fe
);

  logic r_clk_s1;
  logic r_clk_s2;
  logic r_clk_s3;
  logic r_data_s1;
  logic r_data_s2;

  // Synchronizer chains; reset to the idle (released, high) bus level so a
  // reset never produces a spurious falling edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_s3  <= 1'b1;
      r_data_s1 <= 1'b1;
      r_data_s2 <= 1'b1;
    end else begin
      r_clk_s1  <= i_ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_data_s1 <= i_ps2_data;
      r_data_s2 <= r_data_s1;
    end
  end

  // A falling edge is a 1 followed by a 0 on the synchronized clock; the
  // consumer acts on it at the third clk edge after the pin changed.
  assign o_clk_fe = r_clk_s3 & ~r_clk_s2;
  assign o_clk_s  = r_clk_s2;
  assign o_data_s = r_data_s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a
// request-to-send, shifts one command byte out on device clock edges and
// reports the device ACK, a NACK or a timeout.
//
// Request handshake: a byte is taken on any clk edge where tx_valid and
// tx_ready are both high; tx_ready is high only in IDLE, so tx_valid held
// while busy is neither taken nor remembered, and tx_data need only be
// stable in the accepting cycle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned START_TIMEOUT_US = 15_000,
  parameter int unsigned PKT_TIMEOUT_US   = 2_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] dbg_state
);

  localparam int unsigned N_INH   = us2cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned N_START = us2cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
  localparam int unsigned N_PKT   = us2cycles(CLK_FREQ_HZ, PKT_TIMEOUT_US);
  localparam int unsigned N_MAX   = max3(N_INH, N_START, N_PKT);
  localparam int          CNT_W   = $clog2(N_MAX) + 1;

  // Terminal counts: a phase that starts with cnt=0 and ends when cnt hits
  // N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(N_INH - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(N_START - 1);
  localparam logic [CNT_W-1:0] PKT_LAST   = CNT_W'(N_PKT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  ps2_tx_state_t    r_state;
  ps2_tx_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_idx;
  logic [3:0]       w_idx_nxt;
  logic [9:0]       r_frame;      // {stop, parity, d7..d0}
  logic [9:0]       w_frame_nxt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic             r_clk_oe;
  logic             w_clk_oe_nxt;
  logic             r_data_oe;
  logic             w_data_oe_nxt;

  logic             w_clk_s;
  logic             w_data_s;
  logic             w_clk_fe;

  ps2_sync_edge u_sync (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ps2_clk  (ps2_clk_i),
    .i_ps2_data (ps2_data_i),
    .o_clk_s    (w_clk_s),
    .o_data_s   (w_data_s),
    .o_clk_fe   (w_clk_fe)
  );

  // State, counters, latched frame, result code and registered line enables.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_err     <= ERR_OK;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_frame   <= w_frame_nxt;
      r_err     <= w_err_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  // Next-state logic; the line enables are derived from the next state so
  // they change on the same edge as the state and never glitch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_frame_nxt   = r_frame;
    w_err_nxt     = r_err;
    w_data_oe_nxt = r_data_oe;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (tx_valid) begin
          w_frame_nxt = {1'b1, ~^tx_data, tx_data};
          w_err_nxt   = ERR_OK;
          w_state_nxt = INHIBIT;
        end
      end

      INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = REQ;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_DEV;
      end

      WAIT_DEV: begin
        if (r_cnt == START_LAST) begin
          w_err_nxt   = ERR_START_TO;
          w_state_nxt = FINISH;
        end else if (w_clk_fe) begin
          w_data_oe_nxt = ~r_frame[0];
          w_idx_nxt     = 4'd1;
          w_cnt_nxt     = '0;
          w_state_nxt   = SHIFT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      // The packet timer keeps running across SHIFT, ACK_WAIT and LINE_IDLE
      // and wins over a falling edge in the same cycle.
      SHIFT: begin
        if (r_cnt == PKT_LAST) begin
          w_err_nxt   = ERR_PKT_TO;
          w_state_nxt = FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_clk_fe) begin
            if (r_idx == FRAME_END_IDX) begin
              w_state_nxt = ACK_WAIT;
            end else begin
              w_data_oe_nxt = ~r_frame[r_idx];
              w_idx_nxt     = r_idx + 4'd1;
            end
          end
        end
      end

      ACK_WAIT: begin
        if (r_cnt == PKT_LAST) begin
          w_err_nxt   = ERR_PKT_TO;
          w_state_nxt = FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_clk_fe) begin
            if (!w_data_s) begin
              w_state_nxt = LINE_IDLE;
            end else begin
              w_err_nxt   = ERR_NACK;
              w_state_nxt = FINISH;
            end
          end
        end
      end

      LINE_IDLE: begin
        if (r_cnt == PKT_LAST) begin
          w_err_nxt   = ERR_PKT_TO;
          w_state_nxt = FINISH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (w_clk_s && w_data_s) begin
            w_state_nxt = FINISH;
          end
        end
      end

      FINISH: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Clock is pulled low only while inhibiting and requesting.
    w_clk_oe_nxt = (w_state_nxt == INHIBIT) || (w_state_nxt == REQ);

    // Data is held low for the start bit from REQ on, follows the frame in
    // SHIFT, and is released everywhere the device or the idle bus owns it.
    if (w_state_nxt == REQ) begin
      w_data_oe_nxt = 1'b1;
    end else if ((w_state_nxt == IDLE) || (w_state_nxt == INHIBIT) ||
                 (w_state_nxt == FINISH) || (w_state_nxt == ACK_WAIT) ||
                 (w_state_nxt == LINE_IDLE)) begin
      w_data_oe_nxt = 1'b0;
    end
  end

  // Status decode from the registered state.
  always_comb begin
    tx_ready = (r_state == IDLE);
    busy     = (r_state != IDLE);
    tx_done  = (r_state == FINISH);
    tx_err   = (r_state == FINISH) && (r_err != ERR_OK);
  end

  assign err_code    = r_err;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a 10 kHz PS/2 device model on an
// open-drain (wired-AND) bus. Design clock is 1 MHz so 1 cycle = 1 us.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 50;   // device half period in clk cycles (10 kHz)

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [2:0] dbg_state;

  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  always #5 clk = ~clk;

  // Open-drain bus: any side pulling low wins, pull-ups otherwise.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ      (1_000_000),
    .INHIBIT_US       (100),
    .START_TIMEOUT_US (15_000),
    .PKT_TIMEOUT_US   (2_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- monitors ----------------
  int         cyc = 0;
  int         done_cnt = 0;
  logic       done_err = 1'b0;
  logic [1:0] done_code = 2'b00;
  int         doe_fall_cyc = 0;
  logic       doe_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) begin
      done_cnt  <= done_cnt + 1;
      done_err  <= tx_err;
      done_code <= err_code;
    end
    if (doe_prev && !ps2_data_oe) doe_fall_cyc <= cyc;
    doe_prev <= ps2_data_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_ready: tx_ready=%b expected 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL accept_busy: busy=%b expected 1", busy);
    end
  endtask

  // Counts inhibit-only and request cycles until the host releases clock.
  task automatic wait_release(output int n_inh, output int n_req);
    n_inh = 0;
    n_req = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!ps2_clk_oe) break;
      if (ps2_data_oe) n_req++;
      else n_inh++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int budget, output bit got, output int at);
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_done) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
    end
  endtask

  // Device clocks n_fall pulses. Start bit captured at the first falling
  // edge, frame bits d0..d7, parity, stop on rising edges 1..10. With
  // do_ack it pulls data low after the stop bit and releases it after the
  // final rising edge.
  task automatic dev_clock(input int n_fall, input bit do_ack,
                           output logic [10:0] cap, output int fe1_cyc);
    cap     = '0;
    fe1_cyc = -1;
    for (int k = 1; k <= n_fall; k++) begin
      @(negedge clk);
      dev_clk_low = 1'b1;
      if (k == 1) begin
        cap[0]  = ps2_data_i;
        fe1_cyc = cyc;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k <= 10) cap[k] = ps2_data_i;
      if (k == 10 && do_ack) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = 1'b1;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else if (k == 12) begin
        dev_data_low = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_ready !== 1'b1)   begin n_errors++; $display("FAIL rst_ready: got %b expected 1", tx_ready); end
    n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (tx_done !== 1'b0)    begin n_errors++; $display("FAIL rst_done: got %b expected 0", tx_done); end
    n_checks++; if (tx_err !== 1'b0)     begin n_errors++; $display("FAIL rst_err: got %b expected 0", tx_err); end
    n_checks++; if (err_code !== 2'b00)  begin n_errors++; $display("FAIL rst_code: got %b expected 00", err_code); end
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_errors++; $display("FAIL rst_clk_oe: got %b expected 0", ps2_clk_oe); end
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_errors++; $display("FAIL rst_data_oe: got %b expected 0", ps2_data_oe); end
    n_checks++; if (dbg_state !== 3'd0)  begin n_errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_send_enable();
    int n_inh, n_req, fe1, base;
    logic [10:0] cap;
    base = done_cnt;
    send(CMD_ENABLE);
    wait_release(n_inh, n_req);
    n_checks++; if (n_inh != 100) begin n_errors++; $display("FAIL inhibit_len: got %0d expected 100", n_inh); end
    n_checks++; if (n_req != 1)   begin n_errors++; $display("FAIL req_len: got %0d expected 1", n_req); end
    n_checks++; if (ps2_data_oe !== 1'b1) begin n_errors++; $display("FAIL start_bit_oe: got %b expected 1", ps2_data_oe); end
    repeat (10) @(negedge clk);
    dev_clock(12, 1'b1, cap, fe1);
    repeat (20) @(negedge clk);
    n_checks++; if (cap !== 11'h5E8)  begin n_errors++; $display("FAIL f4_frame: got %h expected 5e8", cap); end
    n_checks++; if (cap[9] !== 1'b0)  begin n_errors++; $display("FAIL f4_parity: got %b expected 0", cap[9]); end
    n_checks++; if (done_cnt != base + 1) begin n_errors++; $display("FAIL f4_done_pulses: got %0d expected 1", done_cnt - base); end
    n_checks++; if (done_err !== 1'b0)   begin n_errors++; $display("FAIL f4_err: got %b expected 0", done_err); end
    n_checks++; if (done_code !== 2'b00) begin n_errors++; $display("FAIL f4_code: got %b expected 00", done_code); end
    n_checks++; if (tx_ready !== 1'b1)   begin n_errors++; $display("FAIL f4_ready_after: got %b expected 1", tx_ready); end
  endtask

  task automatic test_send_reset_cmd();
    int n_inh, n_req, fe1, base;
    logic [10:0] cap;
    base = done_cnt;
    send(CMD_RESET);
    wait_release(n_inh, n_req);
    repeat (10) @(negedge clk);
    dev_clock(12, 1'b1, cap, fe1);
    repeat (20) @(negedge clk);
    n_checks++; if (cap !== 11'h7FE)  begin n_errors++; $display("FAIL ff_frame: got %h expected 7fe", cap); end
    n_checks++; if (cap[9] !== 1'b1)  begin n_errors++; $display("FAIL ff_parity: got %b expected 1", cap[9]); end
    n_checks++; if (done_cnt != base + 1) begin n_errors++; $display("FAIL ff_done_pulses: got %0d expected 1", done_cnt - base); end
    n_checks++; if (done_err !== 1'b0)   begin n_errors++; $display("FAIL ff_err: got %b expected 0", done_err); end
  endtask

  // NACK with tx_valid held through the whole transaction; the held request
  // is taken again only once the design is back in IDLE, and that second
  // transaction is left running for the start-timeout test.
  task automatic test_nack_held_valid();
    int n_inh, n_req, fe1, at;
    bit got;
    logic [10:0] cap;
    @(negedge clk);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    wait_release(n_inh, n_req);
    n_checks++; if (tx_ready !== 1'b0) begin n_errors++; $display("FAIL held_valid_ready: got %b expected 0", tx_ready); end
    repeat (10) @(negedge clk);
    fork
      dev_clock(12, 1'b0, cap, fe1);
      begin
        wait_done(3000, got, at);
        n_checks++; if (!got) begin n_errors++; $display("FAIL nack_done: got none expected pulse"); end
        if (got) begin
          n_checks++; if (tx_err !== 1'b1)    begin n_errors++; $display("FAIL nack_err: got %b expected 1", tx_err); end
          n_checks++; if (err_code !== 2'b11) begin n_errors++; $display("FAIL nack_code: got %b expected 11", err_code); end
          n_checks++; if (tx_ready !== 1'b0)  begin n_errors++; $display("FAIL nack_ready_finish: got %b expected 0", tx_ready); end
          @(negedge clk);
          n_checks++; if (tx_ready !== 1'b1)  begin n_errors++; $display("FAIL nack_ready_idle: got %b expected 1", tx_ready); end
          @(negedge clk);
          tx_valid = 1'b0;
          n_checks++; if (busy !== 1'b1)      begin n_errors++; $display("FAIL reaccept_busy: got %b expected 1", busy); end
          n_checks++; if (err_code !== 2'b00) begin n_errors++; $display("FAIL reaccept_code: got %b expected 00", err_code); end
        end
      end
    join
    tx_valid = 1'b0;
    n_checks++; if (cap !== 11'h74A) begin n_errors++; $display("FAIL a5_frame: got %h expected 74a", cap); end
  endtask

  task automatic test_start_timeout();
    int n_inh, n_req, rel, at;
    bit got;
    wait_release(n_inh, n_req);
    rel = cyc;
    wait_done(16000, got, at);
    n_checks++; if (!got) begin n_errors++; $display("FAIL start_to_done: got none expected pulse"); end
    n_checks++; if (at - rel != 15000) begin n_errors++; $display("FAIL start_to_time: got %0d expected 15000", at - rel); end
    n_checks++; if (tx_err !== 1'b1)    begin n_errors++; $display("FAIL start_to_err: got %b expected 1", tx_err); end
    n_checks++; if (err_code !== 2'b01) begin n_errors++; $display("FAIL start_to_code: got %b expected 01", err_code); end
    n_checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin n_errors++; $display("FAIL start_to_oe: got %b%b expected 00", ps2_clk_oe, ps2_data_oe); end
    repeat (5) @(negedge clk);
    n_checks++; if (err_code !== 2'b01) begin n_errors++; $display("FAIL code_held: got %b expected 01", err_code); end
  endtask

  task automatic test_pkt_timeout();
    int n_inh, n_req, fe1, at;
    bit got;
    logic [10:0] cap;
    send(CMD_RESET);
    n_checks++; if (err_code !== 2'b00) begin n_errors++; $display("FAIL accept_clears_code: got %b expected 00", err_code); end
    wait_release(n_inh, n_req);
    repeat (10) @(negedge clk);
    dev_clock(4, 1'b0, cap, fe1);
    wait_done(2500, got, at);
    n_checks++; if (!got) begin n_errors++; $display("FAIL pkt_to_done: got none expected pulse"); end
    n_checks++; if (doe_fall_cyc - fe1 != 3) begin n_errors++; $display("FAIL fe_latency: got %0d expected 3", doe_fall_cyc - fe1); end
    n_checks++; if (at - doe_fall_cyc != 2000) begin n_errors++; $display("FAIL pkt_to_time: got %0d expected 2000", at - doe_fall_cyc); end
    n_checks++; if (err_code !== 2'b10) begin n_errors++; $display("FAIL pkt_to_code: got %b expected 10", err_code); end
    n_checks++; if (tx_err !== 1'b1)    begin n_errors++; $display("FAIL pkt_to_err: got %b expected 1", tx_err); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n_inh, n_req, fe1, base;
    logic [10:0] cap;
    // Reset while inhibiting: clock line must be released next cycle.
    base = done_cnt;
    send(8'h12);
    repeat (50) @(negedge clk);
    n_checks++; if (ps2_clk_oe !== 1'b1) begin n_errors++; $display("FAIL pre_rst_clk_oe: got %b expected 1", ps2_clk_oe); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (ps2_clk_oe !== 1'b0) begin n_errors++; $display("FAIL mid_rst_clk_oe: got %b expected 0", ps2_clk_oe); end
    n_checks++; if (tx_ready !== 1'b1)   begin n_errors++; $display("FAIL mid_rst_ready: got %b expected 1", tx_ready); end
    // Reset while shifting with data held low.
    send(CMD_ENABLE);
    wait_release(n_inh, n_req);
    repeat (10) @(negedge clk);
    dev_clock(2, 1'b0, cap, fe1);
    n_checks++; if (ps2_data_oe !== 1'b1) begin n_errors++; $display("FAIL pre_rst_data_oe: got %b expected 1", ps2_data_oe); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (ps2_data_oe !== 1'b0) begin n_errors++; $display("FAIL mid_rst_data_oe: got %b expected 0", ps2_data_oe); end
    n_checks++; if (ps2_clk_oe !== 1'b0)  begin n_errors++; $display("FAIL mid_rst_clk_oe2: got %b expected 0", ps2_clk_oe); end
    n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt != base) begin n_errors++; $display("FAIL mid_rst_no_done: got %0d expected 0", done_cnt - base); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_send_enable();
    test_send_reset_cmd();
    test_nack_held_valid();
    test_start_timeout();
    test_pkt_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
